// File: rtl/rst_seq.sv
// Reset sequencer: synchronizes PoR release, then releases reset domains one at a time GAP cycles apart.
// Define RST_SEQ_REVERSE_ASSERT_EN to re-assert domains high-to-low on a software reset instead of all at once.
module rst_seq #(
  parameter int NUM_DOM     = 4,
  parameter int GAP         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_req,
  output logic               sw_ack,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               ready
);

  localparam int CW = $clog2(GAP + 1);
  localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOM - 1);

  typedef enum logic [1:0] {IDLE, SEQ, RUN, ASSERT} state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [IW-1:0]            idx, idx_n, idx_dec;
  logic [NUM_DOM-1:0]       dom_n;
  logic                     ready_n, ack_n;
  logic                     armed, armed_n;
  logic                     pend, pend_n;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     rst_s;

  // Deassertion-only synchronizer; assertion stays asynchronous through rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_s   = sync[SYNC_STAGES-1];
  assign idx_dec = idx - IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      dom_rst_n <= '0;
      ready     <= 1'b0;
      sw_ack    <= 1'b0;
      armed     <= 1'b1;
      pend      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      dom_rst_n <= dom_n;
      ready     <= ready_n;
      sw_ack    <= ack_n;
      armed     <= armed_n;
      pend      <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    dom_n   = dom_rst_n;
    ready_n = ready;
    ack_n   = 1'b0;
    armed_n = armed;
    pend_n  = pend;
    if (!sw_req) armed_n = 1'b1;
    case (state)
      IDLE: begin
        dom_n   = '0;
        ready_n = 1'b0;
        if (rst_s) begin
          state_n = SEQ;
          idx_n   = '0;
          cnt_n   = CNT_RELOAD;
        end
      end
      SEQ: begin
        ready_n = 1'b0;
        if (cnt == '0) begin
          for (int i = 0; i < NUM_DOM; i++)
            if (idx == IW'(i)) dom_n[i] = 1'b1;
          cnt_n = CNT_RELOAD;
          if (idx == IDX_LAST) state_n = RUN;
          else                 idx_n   = idx + IW'(1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RUN: begin
        // Acceptance waits for ready so a completing software reset always gets its ack.
        if (ready && sw_req && armed) begin
          armed_n = 1'b0;
          pend_n  = 1'b1;
          ready_n = 1'b0;
          cnt_n   = CNT_RELOAD;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
          if (NUM_DOM == 1) begin
            dom_n   = '0;
            idx_n   = '0;
            state_n = SEQ;
          end else begin
            dom_n[NUM_DOM-1] = 1'b0;
            idx_n            = IDX_LAST;
            state_n          = ASSERT;
          end
`else
          dom_n   = '0;
          idx_n   = '0;
          state_n = SEQ;
`endif
        end else begin
          ready_n = 1'b1;
          if (!ready && pend) begin
            ack_n  = 1'b1;
            pend_n = 1'b0;
          end
        end
      end
      ASSERT: begin
        ready_n = 1'b0;
        if (cnt == '0) begin
          for (int i = 0; i < NUM_DOM; i++)
            if (idx_dec == IW'(i)) dom_n[i] = 1'b0;
          idx_n = idx_dec;
          cnt_n = CNT_RELOAD;
          if (idx_dec == '0) state_n = SEQ;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus pushes expected output changes with their edge numbers,
// a negedge monitor pops and compares every observed change of {dom_rst_n, ready, sw_ack}.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_req;
  logic       sw_ack;
  logic [3:0] dom_rst_n;
  logic       ready;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

`ifdef RST_SEQ_REVERSE_ASSERT_EN
  localparam int SW_ACK = 113;
`else
  localparam int SW_ACK = 65;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] dom;
    logic       rdy;
    logic       ack;
  } exp_t;

  exp_t q[$];

  rst_seq #(.NUM_DOM(4), .GAP(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_req    (sw_req),
    .sw_ack    (sw_ack),
    .dom_rst_n (dom_rst_n),
    .ready     (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] d, input logic r, input logic a);
    exp_t e;
    e.cyc = c; e.dom = d; e.rdy = r; e.ack = a;
    q.push_back(e);
  endtask

  task automatic push_power(input int e0);
    push(e0 + 19, 4'b0001, 1'b0, 1'b0);
    push(e0 + 35, 4'b0011, 1'b0, 1'b0);
    push(e0 + 51, 4'b0111, 1'b0, 1'b0);
    push(e0 + 67, 4'b1111, 1'b0, 1'b0);
    push(e0 + 68, 4'b1111, 1'b1, 1'b0);
  endtask

  task automatic push_sw(input int r);
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    push(r,       4'b0111, 1'b0, 1'b0);
    push(r + 16,  4'b0011, 1'b0, 1'b0);
    push(r + 32,  4'b0001, 1'b0, 1'b0);
    push(r + 48,  4'b0000, 1'b0, 1'b0);
    push(r + 64,  4'b0001, 1'b0, 1'b0);
    push(r + 80,  4'b0011, 1'b0, 1'b0);
    push(r + 96,  4'b0111, 1'b0, 1'b0);
    push(r + 112, 4'b1111, 1'b0, 1'b0);
    push(r + 113, 4'b1111, 1'b1, 1'b1);
    push(r + 114, 4'b1111, 1'b1, 1'b0);
`else
    push(r,      4'b0000, 1'b0, 1'b0);
    push(r + 16, 4'b0001, 1'b0, 1'b0);
    push(r + 32, 4'b0011, 1'b0, 1'b0);
    push(r + 48, 4'b0111, 1'b0, 1'b0);
    push(r + 64, 4'b1111, 1'b0, 1'b0);
    push(r + 65, 4'b1111, 1'b1, 1'b1);
    push(r + 66, 4'b1111, 1'b1, 1'b0);
`endif
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  // Returns 1 ns after edge c.
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every change on the outputs must match the next scoreboard entry.
  logic [5:0] prev = 6'b0;
  always @(negedge clk) begin
    logic [5:0] cur;
    exp_t       e;
    cur = {dom_rst_n, ready, sw_ack};
    if (cur !== prev) begin
      prev = cur;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: edge %0d got %b, expected no change", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || cur !== {e.dom, e.rdy, e.ack}) begin
          fails++;
          $display("FAIL output_change: edge %0d got %b, expected edge %0d value %b",
                   cyc, cur, e.cyc, {e.dom, e.rdy, e.ack});
        end
      end
    end
  end

  initial begin
    int e0, r, p;
    rst    = 1'b0;
    sw_req = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {dom_rst_n, ready, sw_ack}, 6'b0);

    // Power-up, with a sw_req pulse during SEQ that must be ignored.
    rst = 1'b0;
    e0  = cyc;
    push_power(e0);
    go(e0 + 30);
    sw_req = 1'b1;
    go(e0 + 31);
    sw_req = 1'b0;
    go(e0 + 80);

    // Software reset; request held past ack must not retrigger.
    sw_req = 1'b1;
    r = cyc + 1;
    push_sw(r);
    go(r + SW_ACK + 10);
    sw_req = 1'b0;
    go(cyc + 1);
    sw_req = 1'b1;
    r = cyc + 1;
    push_sw(r);
    go(r + SW_ACK + 1);
    sw_req = 1'b0;
    go(cyc + 5);

    // Async reset pulse from RUN, then again at E40 of the restarted sequence.
    p = cyc;
    rst = 1'b1;
    #1 check("async_rst_run", {dom_rst_n, ready, sw_ack}, 6'b0);
    #2 rst = 1'b0;
    push(p, 4'b0000, 1'b0, 1'b0);
    e0 = p;
    push(e0 + 19, 4'b0001, 1'b0, 1'b0);
    push(e0 + 35, 4'b0011, 1'b0, 1'b0);
    go(e0 + 40);
    p = cyc;
    rst = 1'b1;
    #1 check("async_rst_e40", {dom_rst_n, ready, sw_ack}, 6'b0);
    #2 rst = 1'b0;
    push(p, 4'b0000, 1'b0, 1'b0);
    e0 = p;
    push_power(e0);
    go(e0 + 80);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
